btn_debounce: RTL

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce_pkg.sv | 16 +
 rtl/btn_debounce_chan.sv | 128 ++++++++++++
 rtl/btn_debounce.sv | 42 ++++
 3 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared definitions for the button debouncer.
//   rpt_state_e : auto-repeat FSM states (IDLE, DELAY, REPEAT)
//   DB_CNT_W    : debounce counter width (DEBOUNCE_CYCLES < 2^20)
//   RPT_CNT_W   : repeat counter width (repeat periods < 2^24)
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  localparam int unsigned DB_CNT_W  = 20;
  localparam int unsigned RPT_CNT_W = 24;

endpackage

// File: rtl/btn_debounce_chan.sv
// One independent button channel: two-flop synchronizer, debounce counter,
// edge pulses and the auto-repeat FSM. All outputs are registered.
// Ports:
//   clk_i     : system clock (rising edge)
//   rst_i     : asynchronous active-high reset
//   btn_i     : raw, possibly bouncing button input (1 = pressed)
//   level_o   : debounced button state
//   press_o   : one-cycle pulse in the first cycle level_o is high
//   release_o : one-cycle pulse in the first cycle level_o is low
//   repeat_o  : one-cycle auto-repeat pulse while the button is held
module btn_debounce_chan
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 160000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 8000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 2000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  // Compare against limit-1: the counter "reaches" the limit on the edge
  // where it would have been incremented to it, and clears instead.
  localparam logic [DB_CNT_W-1:0]  DB_LAST  = DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_CNT_W-1:0] RD_LAST  = RPT_CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_CNT_W-1:0] RR_LAST  = RPT_CNT_W'(REPEAT_RATE_CYCLES - 1);

  logic                 sync1_q, sync2_q;
  logic [DB_CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic                 level_q, level_d;
  logic                 press_q, release_q, repeat_q;
  logic                 rise_s, fall_s;
  rpt_state_e           state_q;
  logic [RPT_CNT_W-1:0] rpt_cnt_q;

  // Debounce next-state: count cycles the synchronized input disagrees
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_CNT_W'(1);
    end
  end

  assign rise_s = level_d & ~level_q;
  assign fall_s = ~level_d & level_q;

  // Synchronizer, debounce state and edge pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= rise_s;
      release_q <= fall_s;
    end
  end

  // Auto-repeat FSM; a level fall wins over everything so no repeat pulse
  // can land in the release cycle, and a rise restarts the delay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rpt_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (fall_s) begin
        state_q   <= IDLE;
        rpt_cnt_q <= '0;
      end else if (rise_s) begin
        state_q   <= DELAY;
        rpt_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            rpt_cnt_q <= '0;
          end
          DELAY: begin
            if (rpt_cnt_q == RD_LAST) begin
              state_q   <= REPEAT;
              rpt_cnt_q <= '0;
              repeat_q  <= 1'b1;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_CNT_W'(1);
            end
          end
          REPEAT: begin
            if (rpt_cnt_q == RR_LAST) begin
              rpt_cnt_q <= '0;
              repeat_q  <= 1'b1;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + RPT_CNT_W'(1);
            end
          end
          default: begin
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer with press/release pulses and auto-repeat.
// Channels are fully independent; simultaneous events appear together.
// Ports:
//   clk         : system clock (rising edge)
//   rst         : asynchronous active-high reset
//   btn         : raw button inputs, NUM_BTN wide, 1 = pressed
//   btn_level   : debounced registered button state
//   btn_press   : one-cycle pulse per channel when btn_level rises
//   btn_release : one-cycle pulse per channel when btn_level falls
//   btn_repeat  : one-cycle auto-repeat pulse per channel while held
module btn_debounce #(
  parameter int unsigned NUM_BTN             = 4,
  parameter int unsigned DEBOUNCE_CYCLES     = 160000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 8000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
    ) u_chan (
      .clk_i     (clk),
      .rst_i     (rst),
      .btn_i     (btn[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g]),
      .repeat_o  (btn_repeat[g])
    );
  end

endmodule
